// File: rtl/clock_divider_n_if.sv
// Control/status bundle for clock_divider_n: run/load controls in, divided clock and pulses out.
interface clock_divider_n_if #(
   parameter int WIDTH = 8
);
   logic             enable;
   logic             load;
   logic [WIDTH-1:0] div_ratio;
   logic [WIDTH-1:0] high_cnt;
   logic             clockout;
   logic             tick;
   logic             ratio_ack;

   modport master (
      output enable, load, div_ratio, high_cnt,
      input  clockout, tick, ratio_ack
   );

   modport slave (
      input  enable, load, div_ratio, high_cnt,
      output clockout, tick, ratio_ack
   );
endinterface

// File: rtl/clock_divider_n.sv
// Programmable integer clock divider with double-buffered ratio/high time applied at period boundaries.
// Optional CLKDIV_ODD50_EN adds a negedge flop giving exact 50% duty for odd N with H == (N-1)/2.
module clock_divider_n #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic              clockin,
   input  logic              reset,
   clock_divider_n_if.slave  bus
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] cnt_reg, cnt_next;
   logic [WIDTH-1:0] n_act_reg, n_act_next;
   logic [WIDTH-1:0] h_act_reg, h_act_next;
   logic [WIDTH-1:0] n_sh_reg, n_sh_next;
   logic [WIDTH-1:0] h_sh_reg, h_sh_next;
   logic             pending_reg, pending_next;
   logic             pos_reg, pos_next;
   logic             tick_reg, tick_next;
   logic             ack_reg, ack_next;
   logic [WIDTH-1:0] n_clamp, h_clamp;
   logic             boundary;

   always_comb begin
      n_clamp = (bus.div_ratio < WIDTH'(2)) ? WIDTH'(2) : bus.div_ratio;
      if (bus.high_cnt == '0)
         h_clamp = WIDTH'(1);
      else if (bus.high_cnt >= n_clamp)
         h_clamp = n_clamp - 1'b1;
      else
         h_clamp = bus.high_cnt;
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      n_act_next   = n_act_reg;
      h_act_next   = h_act_reg;
      n_sh_next    = n_sh_reg;
      h_sh_next    = h_sh_reg;
      pending_next = pending_reg;
      pos_next     = 1'b0;
      tick_next    = 1'b0;
      ack_next     = 1'b0;
      boundary     = 1'b0;

      if (bus.load) begin
         n_sh_next    = n_clamp;
         h_sh_next    = h_clamp;
         pending_next = 1'b1;
      end

      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (bus.enable) begin
               state_next = RUN;
               boundary   = 1'b1;
            end
         end
         RUN: begin
            if (!bus.enable) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = (cnt_reg == n_act_reg - 1'b1) ? '0 : cnt_reg + 1'b1;
               boundary = (cnt_next == '0);
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase

      // A load landing on the boundary edge bypasses the shadow and takes effect at once.
      if (boundary) begin
         if (bus.load) begin
            n_act_next   = n_clamp;
            h_act_next   = h_clamp;
            pending_next = 1'b0;
            ack_next     = 1'b1;
         end else if (pending_reg) begin
            n_act_next   = n_sh_reg;
            h_act_next   = h_sh_reg;
            pending_next = 1'b0;
            ack_next     = 1'b1;
         end
      end

      if (state_next == RUN) begin
         pos_next  = (cnt_next < h_act_next);
         tick_next = (cnt_next == '0);
      end
   end

   always_ff @(posedge clockin or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         n_act_reg   <= WIDTH'(DEFAULT_DIV);
         h_act_reg   <= WIDTH'(DEFAULT_DIV / 2);
         n_sh_reg    <= WIDTH'(DEFAULT_DIV);
         h_sh_reg    <= WIDTH'(DEFAULT_DIV / 2);
         pending_reg <= 1'b0;
         pos_reg     <= 1'b0;
         tick_reg    <= 1'b0;
         ack_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         n_act_reg   <= n_act_next;
         h_act_reg   <= h_act_next;
         n_sh_reg    <= n_sh_next;
         h_sh_reg    <= h_sh_next;
         pending_reg <= pending_next;
         pos_reg     <= pos_next;
         tick_reg    <= tick_next;
         ack_reg     <= ack_next;
      end
   end

   assign bus.tick      = tick_reg;
   assign bus.ratio_ack = ack_reg;

`ifdef CLKDIV_ODD50_EN
   logic neg_reg;
   logic odd50_sel;

   always_ff @(negedge clockin or negedge reset) begin
      if (!reset)
         neg_reg <= 1'b0;
      else
         neg_reg <= pos_reg;
   end

   // For odd N, (N-1)/2 == N>>1; the half-cycle stretch only applies while running.
   assign odd50_sel    = n_act_reg[0] && (h_act_reg == (n_act_reg >> 1)) && (state_reg == RUN);
   assign bus.clockout = pos_reg | (neg_reg & odd50_sel);
`else
   assign bus.clockout = pos_reg;
`endif
endmodule

// File: tb/tb_clock_divider_n.sv
// Scoreboard bench for clock_divider_n: expected clockout/tick/ratio_ack per edge queued, popped after each edge.
module tb_clock_divider_n;
   logic clockin;
   logic reset;

   clock_divider_n_if #(.WIDTH(8)) bus ();

   clock_divider_n #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
      .clockin (clockin),
      .reset   (reset),
      .bus     (bus)
   );

`ifdef CLKDIV_ODD50_EN
   localparam bit ODD50 = 1'b1;
`else
   localparam bit ODD50 = 1'b0;
`endif

   typedef struct {
      logic co;
      logic tk;
      logic ak;
   } exp_t;

   exp_t exp_q[$];
   logic last_pos;
   int   n_checks;
   int   n_fail;

   initial begin
      clockin = 1'b0;
      forever #5 clockin = ~clockin;
   end

   // Patterns are per-edge strings; sel marks periods whose config qualifies for the odd-50 stretch.
   task automatic push_pat(input string co, input string tk, input string ak, input bit sel);
      exp_t e;
      logic p;
      for (int i = 0; i < co.len(); i++) begin
         p    = (co.getc(i) == "1");
         e.co = p | (sel & ODD50 & last_pos);
         e.tk = (tk.getc(i) == "1");
         e.ak = (ak.getc(i) == "1");
         exp_q.push_back(e);
         last_pos = p;
      end
   endtask

   task automatic do_reset();
      reset         = 1'b0;
      bus.enable    = 1'b0;
      bus.load      = 1'b0;
      bus.div_ratio = '0;
      bus.high_cnt  = '0;
      exp_q.delete();
      last_pos = 1'b0;
      repeat (2) @(posedge clockin);
      #1;
      reset = 1'b1;
   endtask

   task automatic drive_load(input logic ld, input logic [7:0] n, input logic [7:0] h);
      bus.load      = ld;
      bus.div_ratio = n;
      bus.high_cnt  = h;
   endtask

   task automatic test_reset();
      reset         = 1'b0;
      bus.enable    = 1'b1;
      bus.load      = 1'b1;
      bus.div_ratio = 8'd9;
      bus.high_cnt  = 8'd3;
      for (int i = 0; i < 3; i++) begin
         @(posedge clockin);
         #1;
         n_checks++;
         if ({bus.clockout, bus.tick, bus.ratio_ack} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state edge %0d: co/tk/ack=%b%b%b, expected 000", i,
                     bus.clockout, bus.tick, bus.ratio_ack);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_run_default();
      exp_t e;
      do_reset();
      bus.enable = 1'b1;
      push_pat("110011001100", "100010001000", "000000000000", 1'b0);
      for (int i = 0; i < 12; i++) begin
         @(posedge clockin);
         #1;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL run_default edge %0d: no expected entry", i);
         end else begin
            e = exp_q.pop_front();
            if ({bus.clockout, bus.tick, bus.ratio_ack} !== {e.co, e.tk, e.ak}) begin
               n_fail++;
               $display("FAIL run_default edge %0d: co/tk/ack=%b%b%b, expected %b%b%b", i,
                        bus.clockout, bus.tick, bus.ratio_ack, e.co, e.tk, e.ak);
            end
         end
      end
      $display("test_run_default done");
   endtask

   task automatic test_load_midperiod();
      exp_t e;
      do_reset();
      bus.enable = 1'b1;
      push_pat("1100", "1000", "0000", 1'b0);
      push_pat("11000", "10000", "10000", 1'b1);
      push_pat("11000", "10000", "00000", 1'b1);
      push_pat("1", "1", "0", 1'b1);
      for (int i = 0; i < 15; i++) begin
         @(posedge clockin);
         #1;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL load_mid edge %0d: no expected entry", i);
         end else begin
            e = exp_q.pop_front();
            if ({bus.clockout, bus.tick, bus.ratio_ack} !== {e.co, e.tk, e.ak}) begin
               n_fail++;
               $display("FAIL load_mid edge %0d: co/tk/ack=%b%b%b, expected %b%b%b", i,
                        bus.clockout, bus.tick, bus.ratio_ack, e.co, e.tk, e.ak);
            end
         end
         if (i == 1) drive_load(1'b1, 8'd5, 8'd2);
         if (i == 2) drive_load(1'b0, 8'd0, 8'd0);
      end
      $display("test_load_midperiod done");
   endtask

   task automatic test_clamp();
      exp_t e;
      do_reset();
      drive_load(1'b1, 8'd0, 8'd0);
      push_pat("0", "0", "0", 1'b0);
      push_pat("10", "10", "10", 1'b0);
      push_pat("10", "10", "00", 1'b0);
      push_pat("111110", "100000", "100000", 1'b0);
      push_pat("111110", "100000", "000000", 1'b0);
      push_pat("1", "1", "0", 1'b0);
      for (int i = 0; i < 18; i++) begin
         @(posedge clockin);
         #1;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL clamp edge %0d: no expected entry", i);
         end else begin
            e = exp_q.pop_front();
            if ({bus.clockout, bus.tick, bus.ratio_ack} !== {e.co, e.tk, e.ak}) begin
               n_fail++;
               $display("FAIL clamp edge %0d: co/tk/ack=%b%b%b, expected %b%b%b", i,
                        bus.clockout, bus.tick, bus.ratio_ack, e.co, e.tk, e.ak);
            end
         end
         if (i == 0) begin
            drive_load(1'b0, 8'd0, 8'd0);
            bus.enable = 1'b1;
         end
         if (i == 3) drive_load(1'b1, 8'd6, 8'd9);
         if (i == 4) drive_load(1'b0, 8'd0, 8'd0);
      end
      $display("test_clamp done");
   endtask

   task automatic test_back_to_back();
      exp_t e;
      do_reset();
      bus.enable = 1'b1;
      push_pat("1100", "1000", "0000", 1'b0);
      push_pat("11100", "10000", "10000", 1'b0);
      push_pat("110000", "100000", "100000", 1'b0);
      push_pat("1", "1", "0", 1'b0);
      for (int i = 0; i < 16; i++) begin
         @(posedge clockin);
         #1;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL back_to_back edge %0d: no expected entry", i);
         end else begin
            e = exp_q.pop_front();
            if ({bus.clockout, bus.tick, bus.ratio_ack} !== {e.co, e.tk, e.ak}) begin
               n_fail++;
               $display("FAIL back_to_back edge %0d: co/tk/ack=%b%b%b, expected %b%b%b", i,
                        bus.clockout, bus.tick, bus.ratio_ack, e.co, e.tk, e.ak);
            end
         end
         if (i == 3) drive_load(1'b1, 8'd5, 8'd3);
         if (i == 4) drive_load(1'b1, 8'd2, 8'd1);
         if (i == 5) drive_load(1'b1, 8'd6, 8'd2);
         if (i == 6) drive_load(1'b0, 8'd0, 8'd0);
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_disable();
      exp_t e;
      do_reset();
      bus.enable = 1'b1;
      push_pat("11000", "10000", "00000", 1'b0);
      push_pat("11001", "10001", "00000", 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clockin);
         #1;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL disable edge %0d: no expected entry", i);
         end else begin
            e = exp_q.pop_front();
            if ({bus.clockout, bus.tick, bus.ratio_ack} !== {e.co, e.tk, e.ak}) begin
               n_fail++;
               $display("FAIL disable edge %0d: co/tk/ack=%b%b%b, expected %b%b%b", i,
                        bus.clockout, bus.tick, bus.ratio_ack, e.co, e.tk, e.ak);
            end
         end
         if (i == 1) bus.enable = 1'b0;
         if (i == 4) bus.enable = 1'b1;
      end
      $display("test_disable done");
   endtask

   task automatic test_reset_midperiod();
      exp_t e;
      do_reset();
      bus.enable = 1'b1;
      push_pat("11", "10", "00", 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clockin);
         #1;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL reset_mid pre edge %0d: no expected entry", i);
         end else begin
            e = exp_q.pop_front();
            if ({bus.clockout, bus.tick, bus.ratio_ack} !== {e.co, e.tk, e.ak}) begin
               n_fail++;
               $display("FAIL reset_mid pre edge %0d: co/tk/ack=%b%b%b, expected %b%b%b", i,
                        bus.clockout, bus.tick, bus.ratio_ack, e.co, e.tk, e.ak);
            end
         end
         if (i == 0) drive_load(1'b1, 8'd7, 8'd3);
         if (i == 1) drive_load(1'b0, 8'd0, 8'd0);
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({bus.clockout, bus.tick, bus.ratio_ack} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_mid async drop: co/tk/ack=%b%b%b, expected 000",
                  bus.clockout, bus.tick, bus.ratio_ack);
      end
      @(negedge clockin);
      reset    = 1'b1;
      last_pos = 1'b0;
      push_pat("110011001", "100010001", "000000000", 1'b0);
      for (int i = 0; i < 9; i++) begin
         @(posedge clockin);
         #1;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL reset_mid post edge %0d: no expected entry", i);
         end else begin
            e = exp_q.pop_front();
            if ({bus.clockout, bus.tick, bus.ratio_ack} !== {e.co, e.tk, e.ak}) begin
               n_fail++;
               $display("FAIL reset_mid post edge %0d: co/tk/ack=%b%b%b, expected %b%b%b", i,
                        bus.clockout, bus.tick, bus.ratio_ack, e.co, e.tk, e.ak);
            end
         end
      end
      $display("test_reset_midperiod done");
   endtask

   task automatic test_odd_n();
      exp_t e;
      do_reset();
      drive_load(1'b1, 8'd3, 8'd1);
      push_pat("0", "0", "0", 1'b0);
      push_pat("100", "100", "100", 1'b1);
      push_pat("100100", "100100", "000000", 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clockin);
         #1;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL odd_n edge %0d: no expected entry", i);
         end else begin
            e = exp_q.pop_front();
            if ({bus.clockout, bus.tick, bus.ratio_ack} !== {e.co, e.tk, e.ak}) begin
               n_fail++;
               $display("FAIL odd_n edge %0d: co/tk/ack=%b%b%b, expected %b%b%b", i,
                        bus.clockout, bus.tick, bus.ratio_ack, e.co, e.tk, e.ak);
            end
         end
         if (i == 0) begin
            drive_load(1'b0, 8'd0, 8'd0);
            bus.enable = 1'b1;
         end
      end
      $display("test_odd_n done");
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      last_pos = 1'b0;
      test_reset();
      test_run_default();
      test_load_midperiod();
      test_clamp();
      test_back_to_back();
      test_disable();
      test_reset_midperiod();
      test_odd_n();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
